tx_interface: RTL and testbench

- Downstream stage of the UART command parser and ALU; returns the ALU result to the host terminal.
- Latches an 8-bit result when the parser reports a complete command.
- Converts the result to three ASCII decimal digits, with an optional leading '-' in signed mode and a trailing terminator.
- Feeds each byte to the UART transmitter with a start/done handshake, then acknowledges the parser so it can return to idle.

---
 rtl/tx_interface.sv | 153 +++++++++++++++
 tb/tb_tx_interface.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tx_interface.sv
// tx_interface: returns an 8-bit ALU result to the host terminal as ASCII decimal text.
// It latches the result when the parser has one ready and converts it to three decimal
// digits. It then sends an optional '-', the digits and a terminator byte through the UART
// transmitter, one byte per start/done handshake. Finally it acknowledges the parser.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   res_valid    parser has a result ready (level)
//   res          ALU result, sampled in idle when res_valid is high
//   tx_done_tick UART tx finished shifting the current byte (pulse)
//   din          byte presented to UART tx
//   tx_start     UART tx load strobe (pulse)
//   rd           acknowledge to parser (pulse)
//   busy         high whenever not idle
module tx_interface #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned SIGNED = 0,
  parameter logic [7:0]  TERM   = 8'd10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            res_valid,
  input  logic [DBIT-1:0] res,
  input  logic            tx_done_tick,
  output logic [7:0]      din,
  output logic            tx_start,
  output logic            rd,
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StConv, StSend, StWait, StAck} state_e;

  state_e     state_q, state_d;
  logic [7:0] mag_q, mag_d;
  logic       neg_q, neg_d;
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  // Byte selector: 0 = '-', 1..3 = hundreds/tens/units, 4 = terminator.
  // Unsigned output starts at 1 so the sign slot is skipped.
  logic [2:0] sel_q, sel_d;
  logic [7:0] din_q, din_d;
  // Blocks a restart while the parser still holds res_valid high just after our ack.
  logic       armed_q, armed_d;
  logic [7:0] res8;

  assign res8 = res;

  function automatic logic [7:0] seq_byte(input logic [2:0] sel, input logic [3:0] h,
                                          input logic [3:0] t, input logic [3:0] u);
    logic [7:0] b;
    case (sel)
      3'd0:    b = 8'd45;
      3'd1:    b = 8'd48 + {4'd0, h};
      3'd2:    b = 8'd48 + {4'd0, t};
      3'd3:    b = 8'd48 + {4'd0, u};
      default: b = TERM;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    sel_d   = sel_q;
    din_d   = din_q;
    armed_d = armed_q;
    if (!res_valid) armed_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (res_valid && armed_q) begin
          if ((SIGNED != 0) && res8[7]) begin
            mag_d = ~res8 + 8'd1;  // 8'h80 becomes 128, still fits unsigned
            neg_d = 1'b1;
          end else begin
            mag_d = res8;
            neg_d = 1'b0;
          end
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          state_d = StConv;
        end
      end
      StConv: begin
        if (mag_q >= 8'd100) begin
          mag_d  = mag_q - 8'd100;
          hund_d = hund_q + 4'd1;
        end else if (mag_q >= 8'd10) begin
          mag_d  = mag_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          units_d = mag_q[3:0];
          sel_d   = neg_q ? 3'd0 : 3'd1;
          din_d   = seq_byte(sel_d, hund_q, tens_q, mag_q[3:0]);
          state_d = StSend;
        end
      end
      StSend: state_d = StWait;
      StWait: begin
        if (tx_done_tick) begin
          if (sel_q == 3'd4) begin
            state_d = StAck;
          end else begin
            sel_d   = sel_q + 3'd1;
            din_d   = seq_byte(sel_d, hund_q, tens_q, units_q);
            state_d = StSend;
          end
        end
      end
      StAck: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mag_q   <= 8'd0;
      neg_q   <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      sel_q   <= 3'd0;
      din_q   <= 8'd0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      armed_q <= armed_d;
    end
  end

  assign din      = din_q;
  assign tx_start = (state_q == StSend);
  assign rd       = (state_q == StAck);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_tx_interface.sv
// Directed bench for tx_interface: one unsigned and one signed instance, a UART tx model
// that returns tx_done_tick 10 cycles after each tx_start, and hand-computed byte strings.
module tb_tx_interface;

  typedef logic [7:0] bytes_t [5];

  logic       clk = 1'b0;
  logic       reset;
  logic       rv   [2];
  logic [7:0] rs   [2];
  logic       dn   [2];
  logic [7:0] dout [2];
  logic       txs  [2];
  logic       rdo  [2];
  logic       bsy  [2];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_interface #(.DBIT(8), .SIGNED(0), .TERM(8'd10)) u_uns (
    .clk(clk), .reset(reset), .res_valid(rv[0]), .res(rs[0]), .tx_done_tick(dn[0]),
    .din(dout[0]), .tx_start(txs[0]), .rd(rdo[0]), .busy(bsy[0])
  );

  tx_interface #(.DBIT(8), .SIGNED(1), .TERM(8'd10)) u_sgn (
    .clk(clk), .reset(reset), .res_valid(rv[1]), .res(rs[1]), .tx_done_tick(dn[1]),
    .din(dout[1]), .tx_start(txs[1]), .rd(rdo[1]), .busy(bsy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One full transfer on instance s. lat < 0 skips the latency check. stray keeps
  // res_valid high through ack and injects stray done ticks in CONV and IDLE.
  task automatic xfer(input int s, input logic [7:0] r, input int nb, input bytes_t e,
                      input int lat, input bit stray);
    int cyc, starts, rds;
    bit found, stable;
    @(negedge clk);
    rs[s] = r;
    rv[s] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      found = (b > 0) && txs[s];
      cyc = 0;
      while (!found && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
        if (txs[s]) found = 1'b1;
        if (stray && b == 0 && cyc == 1) begin
          dn[s] = 1'b1;
          rs[s] = ~r;
        end else begin
          dn[s] = 1'b0;
        end
      end
      dn[s] = 1'b0;
      chk($sformatf("tx_start seen r=%0d b=%0d", r, b), found, 1);
      if (!found) return;
      if (b == 0 && lat >= 0) chk($sformatf("latency r=%0d", r), cyc, lat);
      chk($sformatf("din r=%0d b=%0d", r, b), dout[s], e[b]);
      starts = 0;
      stable = 1'b1;
      repeat (9) begin
        @(posedge clk);
        #1;
        if (txs[s]) starts++;
        if (dout[s] !== e[b]) stable = 1'b0;
      end
      chk($sformatf("single tx_start r=%0d b=%0d", r, b), starts, 0);
      chk($sformatf("din stable r=%0d b=%0d", r, b), stable, 1);
      @(negedge clk);
      dn[s] = 1'b1;
      @(posedge clk);
      #1;
      dn[s] = 1'b0;
    end
    chk($sformatf("rd after last done r=%0d", r), rdo[s], 1);
    rds = 0;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rdo[s]) rds++;
      if (txs[s]) starts++;
      if (!stray && c >= 1) rv[s] = 1'b0;
      dn[s] = (stray && (c == 1 || c == 3));
    end
    dn[s] = 1'b0;
    chk($sformatf("no extra rd r=%0d", r), rds, 0);
    chk($sformatf("no restart r=%0d", r), starts, 0);
    chk($sformatf("busy low after r=%0d", r), bsy[s], 0);
    chk($sformatf("din holds term r=%0d", r), dout[s], 8'd10);
    rv[s] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, cyc;
    bit found, busy_seen;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0;
      rs[i] = 8'd0;
      dn[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset din %0d", i), dout[i], 8'd0);
      chk($sformatf("reset tx_start %0d", i), txs[i], 0);
      chk($sformatf("reset rd %0d", i), rdo[i], 0);
      chk($sformatf("reset busy %0d", i), bsy[i], 0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Stray done ticks while idle must not start anything.
    @(negedge clk);
    dn[0] = 1'b1;
    dn[1] = 1'b1;
    @(negedge clk);
    dn[0] = 1'b0;
    dn[1] = 1'b0;
    chk("idle tick tx_start", txs[0], 0);
    chk("idle tick busy", bsy[1], 0);

    // Abort with reset while waiting for the first byte to finish.
    @(negedge clk);
    rs[0] = 8'd123;
    rv[0] = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (txs[0]) found = 1'b1;
    end
    chk("abort tx_start seen", found, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv[0] = 1'b0;
    #1;
    chk("abort din", dout[0], 8'd0);
    chk("abort busy", bsy[0], 0);
    chk("abort tx_start", txs[0], 0);
    chk("abort rd", rdo[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    starts = 0;
    busy_seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (txs[0]) starts++;
      if (bsy[0]) busy_seen = 1'b1;
    end
    chk("post-abort tx_start", starts, 0);
    chk("post-abort busy", busy_seen, 0);

    xfer(0, 8'd123, 4, bytes_t'{8'd49, 8'd50, 8'd51, 8'd10, 8'd0}, -1, 1'b0);
    xfer(0, 8'd7,   4, bytes_t'{8'd48, 8'd48, 8'd55, 8'd10, 8'd0}, -1, 1'b0);
    xfer(0, 8'd255, 4, bytes_t'{8'd50, 8'd53, 8'd53, 8'd10, 8'd0},  9, 1'b0);
    xfer(0, 8'd0,   4, bytes_t'{8'd48, 8'd48, 8'd48, 8'd10, 8'd0},  2, 1'b0);
    xfer(1, 8'hF6,  5, bytes_t'{8'd45, 8'd48, 8'd49, 8'd48, 8'd10}, -1, 1'b0);
    xfer(1, 8'h80,  5, bytes_t'{8'd45, 8'd49, 8'd50, 8'd56, 8'd10}, -1, 1'b0);
    xfer(1, 8'h7F,  4, bytes_t'{8'd49, 8'd50, 8'd55, 8'd10, 8'd0}, -1, 1'b0);
    xfer(0, 8'd42,  4, bytes_t'{8'd48, 8'd52, 8'd50, 8'd10, 8'd0},  6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
